// File: rtl/sfc_rd_pkg.sv
// Shared definitions for the SFC tile reader: FSM state encoding and default
// response-buffer depth.
package sfc_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  localparam int DEPTH_DEFAULT = 4;

  // True while a tile is in flight and DRAM responses are expected.
  function automatic logic is_active(input rd_state_t s);
    return (s == ISSUE) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/sfc_rd_fifo.sv
// Synchronous response FIFO for the SFC tile reader. DEPTH must be a power of
// two so the pointers wrap naturally. When empty, head_data keeps showing the
// last word that was popped.
module sfc_rd_fifo
  import sfc_rd_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEFAULT,
  parameter int MEM_WIDTH = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [MEM_WIDTH:0]       push_data,
  input  logic                     pop,
  output logic [MEM_WIDTH:0]       head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [MEM_WIDTH:0] mem_r [DEPTH];
  logic [MEM_WIDTH:0] last_r;
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        count_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign empty     = (count_r == {(AW + 1){1'b0}});
  assign full      = (count_r == DEPTH_C);
  assign count     = count_r;
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Present the head entry, or the last popped word while the FIFO is empty.
  always_comb begin
    head_data = last_r;
    if (empty) begin
      head_data = last_r;
    end else begin
      head_data = mem_r[rd_ptr_r];
    end
  end

  // Storage, pointers, occupancy and last-popped-word register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(MEM_WIDTH + 1){1'b0}};
      end
      last_r   <= {(MEM_WIDTH + 1){1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        last_r   <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sfc_tile_reader.sv
// SFC tile reader: turns one tile's SFC-ordered address stream into DRAM read
// requests, buffers the in-order responses and streams them to the PE array.
// Requests are credit limited so the response FIFO can never overflow.
// Optional build macro: SFC_RD_ERR_CHK_EN (sticky spurious-response flag).
module sfc_tile_reader
  import sfc_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 15,
  parameter int ADDR_WIDTH = 31,
  parameter int MEM_WIDTH  = 63,
  parameter int DEPTH      = DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH:0]   tile_len,
  input  logic [ADDR_WIDTH:0]   addr_in,
  input  logic                  addr_valid,
  output logic                  addr_ready,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_WIDTH:0]   rd_req_addr,
  input  logic                  rd_rsp_valid,
  input  logic [MEM_WIDTH:0]    rd_rsp_data,
  output logic                  out_valid,
  output logic [MEM_WIDTH:0]    out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  tile_done,
  output logic                  err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]       DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]       CNT_ZERO = {CW{1'b0}};
  localparam logic [DATA_WIDTH:0] LEN_ZERO = {(DATA_WIDTH + 1){1'b0}};
  localparam logic [DATA_WIDTH:0] LEN_ONE  = {{DATA_WIDTH{1'b0}}, 1'b1};

  rd_state_t           state_r;
  logic [DATA_WIDTH:0] len_r;
  logic [DATA_WIDTH:0] issued_r;
  logic [DATA_WIDTH:0] delivered_r;
  logic [CW-1:0]       outstanding_r;
  logic                busy_r;
  logic                tile_done_r;

  logic [CW-1:0]       fifo_count_s;
  logic [CW-1:0]       credits_s;
  logic                has_credit_s;
  logic                req_fire_s;
  logic                push_s;
  logic                pop_s;
  logic                fifo_empty_s;
  logic                fifo_full_s;
  logic                last_issue_s;
  logic                last_deliver_s;

  // Credit accounting and request/response/pop handshakes.
  always_comb begin
    credits_s      = DEPTH_C - outstanding_r - fifo_count_s;
    has_credit_s   = (credits_s != CNT_ZERO);
    rd_req_valid   = 1'b0;
    addr_ready     = 1'b0;
    req_fire_s     = 1'b0;
    if (state_r == ISSUE) begin
      rd_req_valid = addr_valid & has_credit_s;
      addr_ready   = rd_req_ready & has_credit_s;
      req_fire_s   = addr_valid & rd_req_ready & has_credit_s;
    end else begin
      rd_req_valid = 1'b0;
      addr_ready   = 1'b0;
      req_fire_s   = 1'b0;
    end
    // A response with nothing outstanding is spurious and is dropped.
    push_s         = rd_rsp_valid & is_active(state_r) &
                     (outstanding_r != CNT_ZERO) & ~fifo_full_s;
    pop_s          = out_ready & ~fifo_empty_s;
    last_issue_s   = (issued_r == (len_r - LEN_ONE));
    last_deliver_s = (delivered_r == (len_r - LEN_ONE));
  end

  assign rd_req_addr = addr_in;
  assign out_valid   = ~fifo_empty_s;
  assign busy        = busy_r;
  assign tile_done   = tile_done_r;

  // Tile FSM with tile counters, outstanding tracking and registered status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      len_r         <= LEN_ZERO;
      issued_r      <= LEN_ZERO;
      delivered_r   <= LEN_ZERO;
      outstanding_r <= CNT_ZERO;
      busy_r        <= 1'b0;
      tile_done_r   <= 1'b0;
    end else begin
      outstanding_r <= outstanding_r + {{(CW - 1){1'b0}}, req_fire_s}
                                     - {{(CW - 1){1'b0}}, push_s};
      case (state_r)
        IDLE: begin
          if (start) begin
            len_r       <= tile_len;
            issued_r    <= LEN_ZERO;
            delivered_r <= LEN_ZERO;
            busy_r      <= 1'b1;
            if (tile_len == LEN_ZERO) begin
              state_r     <= DONE;
              tile_done_r <= 1'b1;
            end else begin
              state_r     <= ISSUE;
              tile_done_r <= 1'b0;
            end
          end else begin
            busy_r      <= 1'b0;
            tile_done_r <= 1'b0;
          end
        end
        ISSUE: begin
          busy_r <= 1'b1;
          if (req_fire_s) begin
            issued_r <= issued_r + LEN_ONE;
          end
          if (pop_s) begin
            delivered_r <= delivered_r + LEN_ONE;
          end
          if (pop_s && last_deliver_s) begin
            state_r     <= DONE;
            tile_done_r <= 1'b1;
          end else if (req_fire_s && last_issue_s) begin
            state_r     <= DRAIN;
            tile_done_r <= 1'b0;
          end else begin
            tile_done_r <= 1'b0;
          end
        end
        DRAIN: begin
          busy_r <= 1'b1;
          if (pop_s) begin
            delivered_r <= delivered_r + LEN_ONE;
          end
          if (pop_s && last_deliver_s) begin
            state_r     <= DONE;
            tile_done_r <= 1'b1;
          end else begin
            tile_done_r <= 1'b0;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          tile_done_r <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          tile_done_r <= 1'b0;
        end
      endcase
    end
  end

  sfc_rd_fifo #(
    .DEPTH     (DEPTH),
    .MEM_WIDTH (MEM_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (rd_rsp_data),
    .pop       (pop_s),
    .head_data (out_data),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

`ifdef SFC_RD_ERR_CHK_EN
  logic err_r;
  logic spurious_s;

  // Detect responses with nothing outstanding or arriving outside a tile.
  always_comb begin
    spurious_s = 1'b0;
    if (rd_rsp_valid && ((outstanding_r == CNT_ZERO) ||
                         (state_r == IDLE) || (state_r == DONE))) begin
      spurious_s = 1'b1;
    end else begin
      spurious_s = 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (spurious_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sfc_tile_reader.sv
// Scoreboard testbench for sfc_tile_reader: a stimulus process queues
// expected request addresses and output words; a monitor compares them as the
// DUT handshakes; a small DRAM model answers each request 2 cycles later.
module tb_sfc_tile_reader;

  localparam int DW = 15;
  localparam int AW = 31;
  localparam int MW = 63;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW:0]   tile_len = '0;
  logic [AW:0]   addr_in = '0;
  logic          addr_valid = 1'b0;
  logic          addr_ready;
  logic          rd_req_valid;
  logic          rd_req_ready = 1'b0;
  logic [AW:0]   rd_req_addr;
  logic          rd_rsp_valid = 1'b0;
  logic [MW:0]   rd_rsp_data = '0;
  logic          out_valid;
  logic [MW:0]   out_data;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          tile_done;
  logic          err;

  always #5 clk = ~clk;

  sfc_tile_reader dut (
    .clk(clk), .rst(rst), .start(start), .tile_len(tile_len),
    .addr_in(addr_in), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_data(rd_rsp_data), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .tile_done(tile_done), .err(err)
  );

  typedef struct {
    logic [MW:0] data;
    int          due;
  } rsp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_cnt = 0;
  int deliv_cnt = 0;
  int done_cnt = 0;
  int tile_deliv = 0;
  int exp_len = 0;
  bit rdy_toggle = 1'b0;
  bit gap_mode = 1'b0;
  bit force_rsp = 1'b0;
  bit addr_fire = 1'b0;

  logic [AW:0] addr_q[$];
  logic [AW:0] exp_addr_q[$];
  logic [MW:0] exp_data_q[$];
  rsp_t        rsp_q[$];

  function automatic logic [MW:0] data_of(input logic [AW:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_point();
    @(posedge clk);
    #2;
  endtask

  task automatic start_tile(input int len);
    drive_point();
    tile_len   = DW'(len);
    start      = 1'b1;
    exp_len    = len;
    tile_deliv = 0;
    drive_point();
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string name);
    for (int i = 0; i < 400; i++) begin
      if (done_cnt > prev) return;
      tick();
    end
    fail_now(name, 64'(done_cnt));
  endtask

  task automatic load(input logic [AW:0] base, input int n_addr, input int n_exp);
    for (int i = 0; i < n_addr; i++) begin
      addr_q.push_back(base + AW'(i));
      if (i < n_exp) begin
        exp_addr_q.push_back(base + AW'(i));
        exp_data_q.push_back(data_of(base + AW'(i)));
      end
    end
  endtask

  // Monitor: compare requests and output words against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (rd_req_valid && rd_req_ready) begin
        req_cnt++;
        check("req_with_addr_ready", 64'(addr_ready), 64'd1);
        if (exp_addr_q.size() == 0) fail_now("unexpected_req", 64'(rd_req_addr));
        else check("req_addr", 64'(rd_req_addr), 64'(exp_addr_q.pop_front()));
        rsp_q.push_back('{data: data_of(rd_req_addr), due: cyc + 2});
      end
      addr_fire = addr_valid && addr_ready;
      if (out_valid && out_ready) begin
        deliv_cnt++;
        tile_deliv++;
        if (exp_data_q.size() == 0) fail_now("unexpected_out", out_data);
        else check("out_data", out_data, exp_data_q.pop_front());
      end
      if (tile_done) begin
        done_cnt++;
        check("done_after_last_pop", 64'(tile_deliv), 64'(exp_len));
      end
    end
  end

  // Environment: address source, DRAM ready policy and DRAM response model.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (addr_fire && addr_q.size() > 0) void'(addr_q.pop_front());
    addr_fire    = 1'b0;
    addr_valid   = (addr_q.size() > 0) && !(gap_mode && (cyc % 3 == 0));
    addr_in      = (addr_q.size() > 0) ? addr_q[0] : '0;
    rd_req_ready = rdy_toggle ? (cyc % 2 == 1) : 1'b1;
    if (force_rsp) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = 64'hDEAD_BEEF_0000_0001;
      force_rsp    = 1'b0;
    end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end else begin
      rd_rsp_valid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, n0;
    logic exp_err;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_ready", 64'(addr_ready), 64'd0);
    check("rst_rd_req_valid", 64'(rd_req_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tile_done", 64'(tile_done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // T1: len 8, free-flowing
    load(32'h100, 8, 8);
    drive_point();
    out_ready = 1'b1;
    r0 = req_cnt; d0 = deliv_cnt; n0 = done_cnt;
    start_tile(8);
    wait_done(n0, "t1_done_timeout");
    repeat (5) tick();
    check("t1_reqs", 64'(req_cnt - r0), 64'd8);
    check("t1_deliv", 64'(deliv_cnt - d0), 64'd8);
    check("t1_done_once", 64'(done_cnt - n0), 64'd1);
    check("t1_idle", 64'(busy), 64'd0);

    // T2: len 8, consumer stalled -> credits stop issue at DEPTH
    load(32'h180, 8, 8);
    drive_point();
    out_ready = 1'b0;
    r0 = req_cnt; d0 = deliv_cnt; n0 = done_cnt;
    start_tile(8);
    repeat (20) tick();
    check("t2_reqs_stalled", 64'(req_cnt - r0), 64'd4);
    check("t2_addr_ready_low", 64'(addr_ready), 64'd0);
    check("t2_out_valid", 64'(out_valid), 64'd1);
    check("t2_busy", 64'(busy), 64'd1);
    drive_point();
    out_ready = 1'b1;
    wait_done(n0, "t2_done_timeout");
    repeat (3) tick();
    check("t2_reqs", 64'(req_cnt - r0), 64'd8);
    check("t2_deliv", 64'(deliv_cnt - d0), 64'd8);

    // T3: len 0
    r0 = req_cnt; n0 = done_cnt;
    drive_point();
    tile_len = '0; start = 1'b1; exp_len = 0; tile_deliv = 0;
    tick();
    check("t3_done_early", 64'(tile_done), 64'd0);
    drive_point();
    start = 1'b0;
    tick();
    check("t3_done_pulse", 64'(tile_done), 64'd1);
    check("t3_busy_in_done", 64'(busy), 64'd1);
    tick();
    check("t3_done_end", 64'(tile_done), 64'd0);
    check("t3_busy_end", 64'(busy), 64'd0);
    check("t3_no_req", 64'(req_cnt - r0), 64'd0);
    check("t3_done_once", 64'(done_cnt - n0), 64'd1);

    // T4: len 5 with ready toggling and address gaps; a 6th address is left over
    load(32'h200, 6, 5);
    drive_point();
    rdy_toggle = 1'b1; gap_mode = 1'b1;
    r0 = req_cnt; d0 = deliv_cnt; n0 = done_cnt;
    start_tile(5);
    wait_done(n0, "t4_done_timeout");
    repeat (4) tick();
    check("t4_reqs", 64'(req_cnt - r0), 64'd5);
    check("t4_deliv", 64'(deliv_cnt - d0), 64'd5);
    check("t4_leftover_addr", 64'(addr_q.size()), 64'd1);
    drive_point();
    rdy_toggle = 1'b0; gap_mode = 1'b0;
    addr_q.delete();
    repeat (2) tick();

    // T5: reset in the middle of a 6-word tile
    load(32'h280, 6, 6);
    r0 = req_cnt;
    start_tile(6);
    for (int i = 0; i < 100; i++) begin
      if (req_cnt - r0 >= 3) break;
      tick();
    end
    check("t5_reached_3", 64'(req_cnt - r0 >= 3), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t5_addr_ready", 64'(addr_ready), 64'd0);
    check("t5_rd_req_valid", 64'(rd_req_valid), 64'd0);
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_tile_done", 64'(tile_done), 64'd0);
    check("t5_err", 64'(err), 64'd0);
    addr_q.delete(); exp_addr_q.delete(); exp_data_q.delete(); rsp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    load(32'h300, 2, 2);
    r0 = req_cnt; d0 = deliv_cnt; n0 = done_cnt;
    start_tile(2);
    wait_done(n0, "t5b_done_timeout");
    repeat (3) tick();
    check("t5b_reqs", 64'(req_cnt - r0), 64'd2);
    check("t5b_deliv", 64'(deliv_cnt - d0), 64'd2);
    check("t5b_done_once", 64'(done_cnt - n0), 64'd1);

    // T6: spurious response while IDLE
`ifdef SFC_RD_ERR_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    drive_point();
    force_rsp = 1'b1;
    repeat (3) tick();
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_err", 64'(err), 64'(exp_err));
    repeat (3) tick();
    check("t6_err_sticky", 64'(err), 64'(exp_err));
    check("t6_scoreboard_empty", 64'(exp_data_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
